// File: rtl/conv10_pkg.sv
// Shared types and sizing for the conv10 weight ROM read path.
package conv10_pkg;
   localparam int NUM       = 10;
   localparam int AW        = 10;
   localparam int DW        = 16;
   localparam int ROM_DEPTH = 1 << AW;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef logic [DW-1:0] weight_vec_t [0:NUM-1];
endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry weight-vector FIFO; an arriving vector is visible at the head in
// the same cycle when the FIFO holds nothing, so an empty FIFO adds no latency.
module weight_skid_fifo
   import conv10_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  weight_vec_t din,
   input  logic        pop,
   output logic [1:0]  count,
   output logic        valid,
   output weight_vec_t head
);
   weight_vec_t mem [0:1];
   logic        wr_ptr;
   logic        rd_ptr;
   logic        empty;
   logic        store;
   logic        take;

   assign empty = (count == 2'd0);
   // a vector that is both pushed and popped while empty never gets stored
   assign store = push && !(empty && pop);
   assign take  = pop && !empty;
   assign valid = !empty || push;

   always_comb begin
      head = '{default: '0};
      if (!empty)
         head = mem[rd_ptr];
      else if (push)
         head = din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++)
            mem[i] <= '{default: '0};
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (store) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (take)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, store} - {1'b0, take};
      end
   end
endmodule

// File: rtl/weight_fetch_seq.sv
// Walks an address window of the conv10 weight ROM bank and streams the
// NUM-wide weight vectors to the MAC array over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; no ROM reads
// RUN   | issuing one read per cycle while the output stage has room
// DRAIN | all reads issued; waiting for the last vector to be accepted
module weight_fetch_seq
   import conv10_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   num_words,
   output logic          busy,
   output logic          done,
   output logic [NUM-1:0] en,
   output logic [AW-1:0] addr_master [0:NUM-1],
   input  logic [DW-1:0] rom_data [0:NUM-1],
   output logic          wt_valid,
   input  logic          wt_ready,
   output logic [DW-1:0] wt_data [0:NUM-1]
);
   localparam logic [AW:0] CNT_ONE = 1;

   state_t        state;
   logic [AW:0]   issued;
   logic [AW:0]   accepted;
   logic [AW:0]   words;
   logic [AW-1:0] base_q;
   logic [AW-1:0] addr_last;
   logic [AW-1:0] addr_cur;
   logic          inflight;
   logic          issue;
   logic          pop;
   logic [1:0]    fifo_count;
   logic [2:0]    occ_after;

   weight_skid_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight),
      .din   (rom_data),
      .pop   (pop),
      .count (fifo_count),
      .valid (wt_valid),
      .head  (wt_data)
   );

   assign pop       = wt_valid && wt_ready;
   assign addr_cur  = base_q + issued[AW-1:0];
   // occupancy the FIFO will have next cycle once the in-flight read lands
   assign occ_after = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
   assign issue     = (state == RUN) && (issued < words) && (occ_after < 3'd2);

   always_comb begin
      en = {NUM{issue}};
      for (int i = 0; i < NUM; i++)
         addr_master[i] = issue ? addr_cur : addr_last;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         issued    <= '0;
         accepted  <= '0;
         words     <= '0;
         base_q    <= '0;
         addr_last <= '0;
         inflight  <= 1'b0;
      end else begin
         done     <= 1'b0;
         inflight <= issue;
         if (issue) begin
            issued    <= issued + CNT_ONE;
            addr_last <= addr_cur;
         end
         if (pop)
            accepted <= accepted + CNT_ONE;
         case (state)
            IDLE: begin
               if (start) begin
                  if (num_words != '0) begin
                     base_q   <= base_addr;
                     words    <= num_words;
                     issued   <= '0;
                     accepted <= '0;
                     busy     <= 1'b1;
                     state    <= RUN;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue && (issued + CNT_ONE == words))
                  state <= DRAIN;
            end
            DRAIN: begin
               if (pop && (accepted + CNT_ONE == words)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_weight_fetch_seq.sv
// Directed and randomized bench for weight_fetch_seq with a ROM model and an
// address/data scoreboard.
module tb_weight_fetch_seq;
   import conv10_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   num_words;
   logic          busy;
   logic          done;
   logic [NUM-1:0] en;
   logic [AW-1:0] addr_master [0:NUM-1];
   logic [DW-1:0] rom_data [0:NUM-1];
   logic          wt_valid;
   logic          wt_ready;
   logic [DW-1:0] wt_data [0:NUM-1];

   weight_fetch_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .num_words   (num_words),
      .busy        (busy),
      .done        (done),
      .en          (en),
      .addr_master (addr_master),
      .rom_data    (rom_data),
      .wt_valid    (wt_valid),
      .wt_ready    (wt_ready),
      .wt_data     (wt_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [NUM*DW-1:0] obs, input logic [NUM*DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rom_word(input int lane, input int a);
      logic [31:0] h;
      h = 32'(lane * ROM_DEPTH + a) * 32'h9E3779B1;
      return h[31:16] ^ h[15:0];
   endfunction

   function automatic logic [NUM*DW-1:0] exp_vec(input int a);
      logic [NUM*DW-1:0] v;
      v = '0;
      for (int i = 0; i < NUM; i++) v[i*DW +: DW] = rom_word(i, a);
      return v;
   endfunction

   logic [NUM*DW-1:0] data_flat;
   logic              lanes_same;
   always_comb begin
      data_flat  = '0;
      lanes_same = 1'b1;
      for (int i = 0; i < NUM; i++) begin
         data_flat[i*DW +: DW] = wt_data[i];
         if (addr_master[i] !== addr_master[0]) lanes_same = 1'b0;
      end
   end

   // ROM bank model: one cycle read latency, garbage when no read was issued
   logic [NUM-1:0] rom_en_q = '0;
   logic [AW-1:0]  rom_addr_q [0:NUM-1];
   always @(posedge clk)
      for (int i = 0; i < NUM; i++)
         rom_data[i] <= rom_en_q[i] ? rom_word(i, int'(rom_addr_q[i])) : 16'($urandom);

   // scoreboard state
   int exp_issue [$];
   int exp_data [$];
   int n_issued, n_accepted, done_cnt, first_valid_cyc, last_pop_cyc, done_cyc;
   logic prev_stall = 1'b0;
   logic [NUM*DW-1:0] prev_data;
   logic pop_m;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         pop_m = wt_valid && wt_ready;
         if (prev_stall) begin
            check("stall_valid", wt_valid, 1);
            check("stall_data", data_flat, prev_data);
         end
         if (en != '0) begin
            check("en_lanes", en, {NUM{1'b1}});
            check("addr_lanes", lanes_same, 1);
            check("issue_rule", (n_issued - n_accepted - int'(pop_m)) < 2, 1);
            if (exp_issue.size() == 0) check("unexpected_en", en, 0);
            else check("issue_addr", addr_master[0], exp_issue.pop_front());
            n_issued++;
         end
         if (pop_m) begin
            if (exp_data.size() == 0) check("extra_vector", wt_valid, 0);
            else check("wt_data", data_flat, exp_vec(exp_data.pop_front()));
            n_accepted++;
            last_pop_cyc = cyc;
         end
         if (wt_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = wt_valid && !wt_ready;
         prev_data  = data_flat;
      end
      for (int i = 0; i < NUM; i++) begin
         rom_en_q[i]   = en[i];
         rom_addr_q[i] = addr_master[i];
      end
   end

   int pat [6] = '{1, 0, 0, 1, 0, 1};

   function automatic logic pick_ready(input int rmode, input int t);
      if (rmode == 0) return 1'b1;
      if (rmode == 1) return pat[t % 6] != 0;
      return $urandom_range(0, 1) != 0;
   endfunction

   task automatic clear_model();
      exp_issue.delete();
      exp_data.delete();
      n_issued = 0; n_accepted = 0; done_cnt = 0;
      first_valid_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
   endtask

   task automatic run_job(input int b, input int n, input int rmode, input logic stray);
      int t;
      int start_cyc;
      clear_model();
      for (int k = 0; k < n; k++) begin
         exp_issue.push_back((b + k) % ROM_DEPTH);
         exp_data.push_back((b + k) % ROM_DEPTH);
      end
      @(posedge clk); #1;
      base_addr = AW'(b);
      num_words = (AW+1)'(n);
      start     = 1'b1;
      wt_ready  = pick_ready(rmode, 0);
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", busy, n > 0);
      t = 1;
      while (done_cnt == 0 && t < 4 * n + 20) begin
         wt_ready = pick_ready(rmode, t);
         start    = stray && (t == 3);
         if (stray && t == 3) begin
            base_addr = AW'(500);
            num_words = (AW+1)'(3);
         end
         if (n > 0 && !done) check("busy_hold", busy, 1);
         @(posedge clk); #1;
         t++;
      end
      start    = 1'b0;
      wt_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("done_count", done_cnt, 1);
      check("delivered", n_accepted, n);
      check("issued", n_issued, n);
      check("leftover", exp_data.size(), 0);
      check("busy_end", busy, 0);
      if (n == 0) begin
         check("zero_done_lat", done_cyc - start_cyc, 1);
      end else begin
         check("done_after_last", done_cyc - last_pop_cyc, 1);
         if (rmode == 0 && !stray) begin
            check("first_valid_lat", first_valid_cyc - start_cyc, 2);
            check("last_vec_lat", last_pop_cyc - start_cyc, n + 1);
         end
      end
   endtask

   int rb, rn;

   initial begin
      rst_n = 1'b0; start = 1'b0; wt_ready = 1'b0;
      base_addr = '0; num_words = '0;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_en", en, 0);
      check("rst_addr", addr_master[0], 0);
      check("rst_valid", wt_valid, 0);
      check("rst_data", data_flat, 0);
      rst_n = 1'b1;

      run_job(0, 4, 0, 1'b0);
      run_job(0, 6, 1, 1'b0);
      run_job(1022, 5, 0, 1'b0);
      run_job(1020, 8, 2, 1'b0);
      run_job(0, 0, 0, 1'b0);
      run_job(0, 1024, 0, 1'b0);
      run_job(30, 10, 2, 1'b1);
      for (int j = 0; j < 5; j++) begin
         rb = int'($urandom_range(0, ROM_DEPTH - 1));
         rn = int'($urandom_range(1, 14));
         run_job(rb, rn, (j % 2 == 0) ? 2 : 0, 1'b0);
      end

      // reset in the middle of a stalled run
      clear_model();
      for (int k = 0; k < 20; k++) begin
         exp_issue.push_back(100 + k);
         exp_data.push_back(100 + k);
      end
      @(posedge clk); #1;
      base_addr = AW'(100); num_words = (AW+1)'(20); start = 1'b1; wt_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_busy", busy, 1);
      check("pre_rst_valid", wt_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", wt_valid, 0);
      check("mid_rst_en", en, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_data", data_flat, 0);
      clear_model();
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_job(7, 2, 2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
